// File: rtl/rubiks_pkg.sv
// Shared types and constants for the WS2812 frame scheduler.
// Holds the cube orientation widths, the scheduler state type, the default
// timing constants for a 40 MHz clock, and a small max helper that sizes
// the shared watchdog/latch counter.
package rubiks_pkg;

    localparam int unsigned SQ_W     = 3;           // colour code per square
    localparam int unsigned FACE_W   = 9 * SQ_W;    // 9 squares per face
    localparam int unsigned ORIENT_W = 6 * FACE_W;  // 6 faces -> 162 bits

    localparam int unsigned CLK_HZ   = 40_000_000;
    localparam int unsigned LATCH_US = 60;

    localparam int unsigned LATCH_CYCLES_DEF    = (CLK_HZ / 1_000_000) * LATCH_US;
    localparam int unsigned WATCHDOG_CYCLES_DEF = 400_000;
    localparam int unsigned REFRESH_CYCLES_DEF  = 1_333_333;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        LATCH
    } sched_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812_frame_scheduler_if.sv
// Scheduler bus: groups the MCU/SPI load path, the core handshake and the
// status outputs.
//   load_pulse, orientation_in : new orientation from the SPI receiver
//   frame_done                 : end-of-frame pulse from the datastream core
//   frame_start, orientation_out : frame start pulse and data to the core
//   busy, done, error          : status to the MCU
// The slave modport is the scheduler; master is the surrounding system.
interface ws2812_frame_scheduler_if;
    import rubiks_pkg::*;

    logic                load_pulse;
    logic [ORIENT_W-1:0] orientation_in;
    logic                frame_done;
    logic                frame_start;
    logic [ORIENT_W-1:0] orientation_out;
    logic                busy;
    logic                done;
    logic                error;

    modport slave (
        input  load_pulse, orientation_in, frame_done,
        output frame_start, orientation_out, busy, done, error
    );

    modport master (
        output load_pulse, orientation_in, frame_done,
        input  frame_start, orientation_out, busy, done, error
    );

endinterface

// File: rtl/cycle_timer.sv
// Loadable saturating down-counter.
//   clk, reset : clock and synchronous active-high reset (count -> 0)
//   load       : load load_val this cycle (takes priority over en)
//   load_val   : value to load
//   en         : decrement by one when non-zero
//   zero       : count is currently zero
module cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// WS2812 frame scheduler: sequences LED-matrix refreshes between the SPI
// orientation receiver and the face/datastream core.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : ws2812_frame_scheduler_if.slave (load path, core handshake, status)
// Optional build macro AUTO_REFRESH_EN: adds a refresh counter that re-sends
// the current orientation every REFRESH_CYCLES while idle.
module ws2812_frame_scheduler
    import rubiks_pkg::*;
#(
    parameter int unsigned LATCH_CYCLES    = LATCH_CYCLES_DEF,
    parameter int unsigned WATCHDOG_CYCLES = WATCHDOG_CYCLES_DEF
`ifdef AUTO_REFRESH_EN
    ,
    parameter int unsigned REFRESH_CYCLES  = REFRESH_CYCLES_DEF
`endif
) (
    input logic                      clk,
    input logic                      reset,
    ws2812_frame_scheduler_if.slave  bus
);

    // Watchdog and latch gap share one counter; they are never live together.
    localparam int unsigned TMR_W = $clog2(max_u(WATCHDOG_CYCLES, LATCH_CYCLES) + 1);

    // Loaded with N-1 so that BUSY/LATCH last exactly N cycles: the exit is
    // decided in the cycle the counter reads zero.
    localparam logic [TMR_W-1:0] WD_LOAD    = TMR_W'(WATCHDOG_CYCLES - 1);
    localparam logic [TMR_W-1:0] LATCH_LOAD = TMR_W'(LATCH_CYCLES - 1);

    sched_state_t        state_q, state_d;
    logic [ORIENT_W-1:0] shadow_q, shadow_d;
    logic [ORIENT_W-1:0] orient_q, orient_d;
    logic                pending_q, pending_d;
    logic                from_load_q, from_load_d;
    logic                frame_start_q, frame_start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_en;
    logic             tmr_zero;
    logic             start_load;
    logic             start_refresh;

    cycle_timer #(
        .WIDTH (TMR_W)
    ) u_wd_latch_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

`ifdef AUTO_REFRESH_EN
    localparam int unsigned RF_W = $clog2(REFRESH_CYCLES + 1);

    logic refresh_zero;

    // Reloaded in every START cycle, so the interval runs frame start to frame start.
    cycle_timer #(
        .WIDTH (RF_W)
    ) u_refresh_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (frame_start_q),
        .load_val (RF_W'(REFRESH_CYCLES)),
        .en       (1'b1),
        .zero     (refresh_zero)
    );
`endif

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        orient_d      = orient_q;
        pending_d     = pending_q;
        from_load_d   = from_load_q;
        done_d        = done_q;
        error_d       = error_q;
        tmr_load      = 1'b0;
        tmr_load_val  = '0;
        tmr_en        = (state_q == BUSY) || (state_q == LATCH);
        start_load    = 1'b0;
        start_refresh = 1'b0;

        if (bus.load_pulse) begin
            shadow_d = bus.orientation_in;
            done_d   = 1'b0;
            if (state_q != IDLE) begin
                pending_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.load_pulse || pending_q) begin
                    start_load = 1'b1;
`ifdef AUTO_REFRESH_EN
                end else if (refresh_zero) begin
                    start_refresh = 1'b1;
`endif
                end
            end
            START: begin
                // A load landing in START is queued for the next frame.
                pending_d    = bus.load_pulse;
                tmr_load     = 1'b1;
                tmr_load_val = WD_LOAD;
                state_d      = BUSY;
            end
            BUSY: begin
                if (bus.frame_done) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = LATCH_LOAD;
                    state_d      = LATCH;
                end else if (tmr_zero) begin
                    error_d      = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = LATCH_LOAD;
                    state_d      = LATCH;
                end
            end
            LATCH: begin
                if (tmr_zero) begin
                    if (pending_q || bus.load_pulse) begin
                        start_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        if (from_load_q) begin
                            done_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Data is switched on entry to START so it is valid with frame_start.
        if (start_load) begin
            state_d     = START;
            orient_d    = bus.load_pulse ? bus.orientation_in : shadow_q;
            from_load_d = 1'b1;
        end else if (start_refresh) begin
            state_d     = START;
            from_load_d = 1'b0;
        end

        frame_start_d = (state_d == START);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            orient_q      <= '0;
            pending_q     <= 1'b0;
            from_load_q   <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            orient_q      <= orient_d;
            pending_q     <= pending_d;
            from_load_q   <= from_load_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign bus.frame_start     = frame_start_q;
    assign bus.orientation_out = orient_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.error           = error_q;

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Directed self-checking bench for ws2812_frame_scheduler. Uses the default
// latch gap (2400) and a shortened watchdog (3000). With AUTO_REFRESH_EN
// defined it runs the periodic re-send scenario with REFRESH_CYCLES=5000.
module tb_ws2812_frame_scheduler;
    import rubiks_pkg::*;

    localparam int unsigned TB_LATCH = 2400;
    localparam int unsigned TB_WD    = 3000;
    localparam int unsigned TB_RF    = 5000;

    localparam logic [ORIENT_W-1:0] PAT_A = {54{3'd1}};
    localparam logic [ORIENT_W-1:0] PAT_B = {54{3'd2}};
    localparam logic [ORIENT_W-1:0] PAT_C = {18{9'h1a5}};
    localparam logic [ORIENT_W-1:0] PAT_E = {6{27'h5a5a5a5}};
    localparam logic [ORIENT_W-1:0] PAT_F = {54{3'd6}};
    localparam logic [ORIENT_W-1:0] PAT_G = {18{9'h0f3}};
    localparam logic [ORIENT_W-1:0] PAT_H = {54{3'd7}};
    localparam logic [ORIENT_W-1:0] PAT_X = {27{6'h2b}};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   fs_count = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    ws2812_frame_scheduler_if bus();

    ws2812_frame_scheduler #(
        .LATCH_CYCLES    (TB_LATCH),
        .WATCHDOG_CYCLES (TB_WD)
`ifdef AUTO_REFRESH_EN
        ,
        .REFRESH_CYCLES  (TB_RF)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frame_start === 1'b1) fs_count <= fs_count + 1;
    end

    task automatic check_eq(input string tag, input logic [ORIENT_W-1:0] got,
                            input logic [ORIENT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Pulse load with data d for one cycle; returns in the following cycle.
    task automatic load(input logic [ORIENT_W-1:0] d);
        bus.load_pulse     = 1'b1;
        bus.orientation_in = d;
        tick();
        bus.load_pulse     = 1'b0;
    endtask

    task automatic pulse_done();
        bus.frame_done = 1'b1;
        tick();
        bus.frame_done = 1'b0;
    endtask

`ifdef AUTO_REFRESH_EN
    task automatic wait_fs(input string tag, input int bound, output int c);
        for (int i = 0; i < bound && bus.frame_start !== 1'b1; i++) tick();
        check_eq(tag, bus.frame_start, 1'b1);
        c = cyc;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 10000 && bus.busy !== 1'b0; i++) tick();
        check_eq(tag, bus.busy, 1'b0);
    endtask

    // Core stand-in: finish the frame 50 cycles after its start.
    task automatic serve();
        ticks(50);
        pulse_done();
    endtask
`endif

    initial begin
        int f0;
        int c0;
        int c1;
        int c2;
        bus.load_pulse     = 1'b0;
        bus.orientation_in = '0;
        bus.frame_done     = 1'b0;
        ticks(3);
        check_eq("rst_frame_start", bus.frame_start, 1'b0);
        check_eq("rst_orient", bus.orientation_out, '0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_done", bus.done, 1'b0);
        check_eq("rst_error", bus.error, 1'b0);
        reset = 1'b0;

`ifndef AUTO_REFRESH_EN
        // Load A in IDLE -> frame_start in the next cycle only.
        tick();
        check_eq("idle_no_start", bus.frame_start, 1'b0);
        load(PAT_A);
        check_eq("a_start", bus.frame_start, 1'b1);
        check_eq("a_orient", bus.orientation_out, PAT_A);
        check_eq("a_busy", bus.busy, 1'b1);
        check_eq("a_done", bus.done, 1'b0);
        tick();
        check_eq("a_start_one_cycle", bus.frame_start, 1'b0);

        // frame_done at M: busy through M+2400, idle and done at M+2401.
        ticks(20);
        f0 = fs_count;
        pulse_done();
        ticks(TB_LATCH - 1);
        check_eq("a_latch_busy", bus.busy, 1'b1);
        check_eq("a_latch_done", bus.done, 1'b0);
        tick();
        check_eq("a_idle_busy", bus.busy, 1'b0);
        check_eq("a_idle_done", bus.done, 1'b1);
        check_eq("a_no_extra_start", fs_count, f0);
        check_eq("a_orient_hold", bus.orientation_out, PAT_A);

        // Stray frame_done in IDLE is ignored.
        pulse_done();
        ticks(3);
        check_eq("stray_done_busy", bus.busy, 1'b0);
        check_eq("stray_done_fs", fs_count, f0);

        // X starts a frame; B then C arrive during BUSY; C is sent after the gap.
        load(PAT_X);
        check_eq("x_start", bus.frame_start, 1'b1);
        check_eq("x_done_cleared", bus.done, 1'b0);
        ticks(5);
        load(PAT_B);
        ticks(3);
        load(PAT_C);
        check_eq("x_orient_stable", bus.orientation_out, PAT_X);
        ticks(10);
        f0 = fs_count;
        pulse_done();
        ticks(TB_LATCH - 1);
        check_eq("c_gap_no_start", bus.frame_start, 1'b0);
        tick();
        check_eq("c_start", bus.frame_start, 1'b1);
        check_eq("c_orient", bus.orientation_out, PAT_C);
        check_eq("c_done", bus.done, 1'b0);
        tick();
        check_eq("c_single_extra", fs_count, f0 + 1);
        ticks(10);
        pulse_done();
        ticks(TB_LATCH - 1);
        check_eq("c_latch_done", bus.done, 1'b0);
        tick();
        check_eq("c_idle_done", bus.done, 1'b1);
        check_eq("c_idle_busy", bus.busy, 1'b0);

        // Watchdog: no frame_done -> error after TB_WD cycles of BUSY.
        load(PAT_E);
        check_eq("e_start", bus.frame_start, 1'b1);
        ticks(TB_WD);
        check_eq("wd_not_yet", bus.error, 1'b0);
        check_eq("wd_busy", bus.busy, 1'b1);
        tick();
        check_eq("wd_error", bus.error, 1'b1);
        check_eq("wd_latch_busy", bus.busy, 1'b1);
        ticks(TB_LATCH);
        check_eq("wd_idle", bus.busy, 1'b0);
        load(PAT_F);
        check_eq("f_start", bus.frame_start, 1'b1);
        check_eq("f_orient", bus.orientation_out, PAT_F);
        check_eq("f_error_sticky", bus.error, 1'b1);

        // Reset during BUSY.
        ticks(3);
        f0 = fs_count;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_busy", bus.busy, 1'b0);
        check_eq("mid_rst_fs", bus.frame_start, 1'b0);
        check_eq("mid_rst_orient", bus.orientation_out, '0);
        check_eq("mid_rst_error", bus.error, 1'b0);
        check_eq("mid_rst_done", bus.done, 1'b0);
        ticks(5);
        check_eq("mid_rst_no_start", fs_count, f0);
        load(PAT_G);
        check_eq("g_start", bus.frame_start, 1'b1);
        check_eq("g_orient", bus.orientation_out, PAT_G);

        // Load coincident with frame_done: gap still honoured before H.
        ticks(10);
        bus.load_pulse     = 1'b1;
        bus.orientation_in = PAT_H;
        bus.frame_done     = 1'b1;
        tick();
        bus.load_pulse     = 1'b0;
        bus.frame_done     = 1'b0;
        ticks(TB_LATCH - 1);
        check_eq("h_gap_no_start", bus.frame_start, 1'b0);
        check_eq("h_gap_busy", bus.busy, 1'b1);
        tick();
        check_eq("h_start", bus.frame_start, 1'b1);
        check_eq("h_orient", bus.orientation_out, PAT_H);
`else
        // Load A right after reset; then idle refreshes re-send A.
        load(PAT_A);
        check_eq("a_start", bus.frame_start, 1'b1);
        check_eq("a_orient", bus.orientation_out, PAT_A);
        c0 = cyc;
        serve();
        wait_idle("a_idle");
        check_eq("a_done", bus.done, 1'b1);
        wait_fs("rf1_start", TB_RF + 100, c1);
        check_eq("rf1_period", c1 - c0, TB_RF + 2);
        check_eq("rf1_orient", bus.orientation_out, PAT_A);
        serve();
        wait_fs("rf2_start", TB_RF + 100, c2);
        check_eq("rf2_period", c2 - c1, TB_RF + 2);
        check_eq("rf2_orient", bus.orientation_out, PAT_A);
        check_eq("rf2_done", bus.done, 1'b1);
        serve();
        // Load in the cycle the refresh counter expires: load data wins.
        while (cyc < c2 + int'(TB_RF) + 1) tick();
        load(PAT_B);
        check_eq("b_start", bus.frame_start, 1'b1);
        check_eq("b_orient", bus.orientation_out, PAT_B);
        check_eq("b_done", bus.done, 1'b0);
        serve();
        wait_idle("b_idle");
        check_eq("b_final_done", bus.done, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
